// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported word memory between instruction fetch (IF) and data (DM).
// DM has fixed priority. A starvation counter forces an IF grant after STARVE_MAX DM wins over a waiting IF.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_dm
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_dm;
  logic          dm_win;
  logic          idle;

  assign idle   = (state == IDLE);
  // DM loses only when IF is waiting and has already been passed over STARVE_MAX times
  assign dm_win = dm_req & ~(if_req & (starve_cnt == SW'(STARVE_MAX)));

  // Gated with rst_n so nothing is granted while reset is asserted
  assign dm_gnt   = rst_n & idle & dm_win;
  assign if_gnt   = rst_n & idle & if_req & ~dm_win;
  assign stall_if = rst_n & if_req & ~if_gnt;
  assign stall_dm = rst_n & dm_req & ~dm_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_gnt) begin
            state     <= ACCESS;
            cnt       <= 4'(MEM_LAT - 1);
            owner_dm  <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (if_gnt) begin
            state      <= ACCESS;
            cnt        <= 4'(MEM_LAT - 1);
            owner_dm   <= 1'b0;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner_dm) begin
              dm_rvalid <= 1'b1;
              // Stores only acknowledge; the last load value stays visible
              if (!mem_we)
                dm_rdata <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
